// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side bus shared by the logger (port 0) and SPI host (port 1).
interface sram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, busy;
    logic [DATA_W-1:0] rdata;
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, busy, rdata
    );
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, busy, rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter driving an async SRAM through setup, strobe and hold phases.
module sram_arbiter #(
    parameter int ADDR_W        = 17,
    parameter int DATA_W        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rstn,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] addr,
    output logic              cen,
    output logic              oen,
    output logic              wen,
    output logic [DATA_W-1:0] dq_o,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_i
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t            state, state_n;
    logic              last_gnt, last_gnt_n, gnt, gnt_n, pick, we_r, we_n;
    logic              cen_n, oen_n, wen_n, dq_oe_n;
    logic              ack0, ack0_n, ack1, ack1_n, busy, busy_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] dq_o_n, rdata, rdata_n;
    assign bus.ack0  = ack0;
    assign bus.ack1  = ack1;
    assign bus.busy  = busy;
    assign bus.rdata = rdata;
    // on a tie the port that was not served last wins
    assign pick = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
    always_comb begin
        state_n    = state;
        last_gnt_n = last_gnt;
        gnt_n      = gnt;
        we_n       = we_r;
        cnt_n      = cnt;
        addr_n     = addr;
        dq_o_n     = dq_o;
        cen_n      = cen;
        oen_n      = oen;
        wen_n      = wen;
        dq_oe_n    = dq_oe;
        rdata_n    = rdata;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        unique case (state)
            IDLE: if (bus.req0 || bus.req1) begin
                gnt_n      = pick;
                last_gnt_n = pick;
                we_n       = pick ? bus.we1 : bus.we0;
                addr_n     = pick ? bus.addr1 : bus.addr0;
                dq_o_n     = pick ? bus.wdata1 : bus.wdata0;
                cen_n      = 1'b0;
                dq_oe_n    = pick ? bus.we1 : bus.we0;
                state_n    = SETUP;
            end
            SETUP: begin
                wen_n   = ~we_r;
                oen_n   = we_r;
                cnt_n   = 4'(STROBE_CYCLES - 1);
                state_n = STROBE;
            end
            STROBE: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
            else begin
                oen_n   = 1'b1;
                wen_n   = 1'b1;
                rdata_n = we_r ? rdata : dq_i;
                ack0_n  = ~gnt;
                ack1_n  = gnt;
                state_n = HOLD;
            end
            HOLD: begin
                cen_n   = 1'b1;
                dq_oe_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            we_r     <= 1'b0;
            cnt      <= '0;
            addr     <= '0;
            dq_o     <= '0;
            rdata    <= '0;
            cen      <= 1'b1;
            oen      <= 1'b1;
            wen      <= 1'b1;
            dq_oe    <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            last_gnt <= last_gnt_n;
            gnt      <= gnt_n;
            we_r     <= we_n;
            cnt      <= cnt_n;
            addr     <= addr_n;
            dq_o     <= dq_o_n;
            rdata    <= rdata_n;
            cen      <= cen_n;
            oen      <= oen_n;
            wen      <= wen_n;
            dq_oe    <= dq_oe_n;
            ack0     <= ack0_n;
            ack1     <= ack1_n;
            busy     <= busy_n;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random and directed traffic on both ports, checked cycle by cycle
// against a transaction-level timing model and a shadow copy of the SRAM contents.
module tb_sram_arbiter;
    localparam int AW = 17;
    localparam int DW = 8;
    localparam int S  = 2;
    typedef struct packed {logic we; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    logic [AW-1:0] addr, addr1;
    logic          cen, oen, wen, dq_oe, cen1, oen1, wen1, dq_oe1;
    logic [DW-1:0] dq_o, dq_i, dq_o1, dq_i1;
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(S)) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .addr(addr), .cen(cen), .oen(oen),
        .wen(wen), .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i));
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1), .addr(addr1), .cen(cen1), .oen(oen1),
        .wen(wen1), .dq_o(dq_o1), .dq_oe(dq_oe1), .dq_i(dq_i1));
    logic [DW-1:0] mem [int];
    logic [DW-1:0] mem1 [int];
    logic [DW-1:0] shadow [int];
    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 37 + 92);
    endfunction
    function automatic logic [DW-1:0] sram_rd(input int a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction
    function automatic logic [DW-1:0] sram1_rd(input int a);
        return mem1.exists(a) ? mem1[a] : init_val(a);
    endfunction
    function automatic logic [DW-1:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction
    // SRAM pins: writes land while wen is low, read data is presented while oen is low
    always @(negedge clk) begin
        if (!cen && !wen) mem[int'(addr)] = dq_o;
        dq_i = (!cen && !oen) ? sram_rd(int'(addr)) : '0;
        if (!cen1 && !wen1) mem1[int'(addr1)] = dq_o1;
        dq_i1 = (!cen1 && !oen1) ? sram1_rd(int'(addr1)) : '0;
    end
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    acc_t          q [2][$];
    logic          act [2];
    acc_t          cur_r [2];
    int            last = 1;
    bit            cv = 1'b0;
    int            cp = 0;
    int            ce0 = 0;
    acc_t          ca;
    logic [DW-1:0] last_rd = '0;
    int            gnt_log [$];
    int            ack_log [$];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    function automatic acc_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t r;
        r.we = we;
        r.a  = a;
        r.d  = d;
        return r;
    endfunction
    function automatic acc_t rand_acc();
        return mk(1'($urandom_range(1)),
                  ($urandom_range(9) == 0) ? AW'(17'h1FFFF) : AW'($urandom_range(7)),
                  DW'($urandom));
    endfunction
    task automatic drive();
        bus.req0 = act[0]; bus.we0 = cur_r[0].we; bus.addr0 = cur_r[0].a; bus.wdata0 = cur_r[0].d;
        bus.req1 = act[1]; bus.we1 = cur_r[1].we; bus.addr1 = cur_r[1].a; bus.wdata1 = cur_r[1].d;
    endtask
    function automatic bit quiet();
        return !cv && !act[0] && !act[1] && q[0].size() == 0 && q[1].size() == 0;
    endfunction
    // one clock: check outputs against the access timeline, then move requesters and the model on
    task automatic step(input bit rnd);
        bit       in_acc, ack_now;
        logic [1:0] ack_seen;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        in_acc  = cv && cyc >= ce0 && cyc <= ce0 + S + 1;
        ack_now = cv && cyc == ce0 + S + 1;
        if (ack_now) begin
            if (ca.we) shadow[int'(ca.a)] = ca.d;
            else last_rd = shadow_rd(int'(ca.a));
        end
        chk("busy", 32'(bus.busy), 32'(in_acc));
        chk("cen", 32'(cen), 32'(!in_acc));
        chk("wen", 32'(wen), 32'(!(cv && ca.we && cyc > ce0 && cyc <= ce0 + S)));
        chk("oen", 32'(oen), 32'(!(cv && !ca.we && cyc > ce0 && cyc <= ce0 + S)));
        chk("dq_oe", 32'(dq_oe), 32'(in_acc && ca.we));
        chk("ack0", 32'(bus.ack0), 32'(ack_now && cp == 0));
        chk("ack1", 32'(bus.ack1), 32'(ack_now && cp == 1));
        chk("rdata", 32'(bus.rdata), 32'(last_rd));
        if (in_acc) begin
            chk("addr", 32'(addr), 32'(ca.a));
            if (ca.we) chk("dq_o", 32'(dq_o), 32'(ca.d));
        end
        if (bus.ack1) ack_log.push_back(cyc);
        if (cv && cyc >= ce0 + S + 2) cv = 1'b0;
        ack_seen = {bus.ack1, bus.ack0};
        for (int p = 0; p < 2; p++) begin
            if (act[p] && ack_seen[p]) act[p] = 1'b0;
            if (!act[p] && rnd && q[p].size() == 0 && $urandom_range(2) == 0) q[p].push_back(rand_acc());
            if (!act[p] && q[p].size() != 0) begin
                cur_r[p] = q[p].pop_front();
                act[p]   = 1'b1;
            end
        end
        drive();
        if (!cv && (act[0] || act[1])) begin
            cp   = (act[0] && act[1]) ? 1 - last : (act[1] ? 1 : 0);
            last = cp;
            cv   = 1'b1;
            ce0  = cyc + 1;
            ca   = cur_r[cp];
            gnt_log.push_back(cp);
        end
    endtask
    task automatic settle(input int budget);
        int n = 0;
        while (!quiet() && n < budget) begin
            step(1'b0);
            n++;
        end
        chk("settle", 32'(quiet()), 32'd1);
    endtask
    task automatic s1_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int ack_at, output int low_w, output int low_r);
        bus1.req0 = 1'b1; bus1.we0 = we; bus1.addr0 = a; bus1.wdata0 = d;
        ack_at = -1;
        low_w  = 0;
        low_r  = 0;
        for (int k = 0; k < 12 && ack_at < 0; k++) begin
            @(negedge clk);
            if (!wen1) low_w++;
            if (!oen1) low_r++;
            if (bus1.ack0) begin
                ack_at    = k;
                bus1.req0 = 1'b0;
            end
        end
        bus1.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int base, ack_at, low_w, low_r;
        for (int p = 0; p < 2; p++) begin
            act[p]   = 1'b0;
            cur_r[p] = '0;
        end
        drive();
        bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.we0 = 1'b0; bus1.we1 = 1'b0;
        bus1.addr0 = '0; bus1.addr1 = '0; bus1.wdata0 = '0; bus1.wdata1 = '0;
        mem[16]    = 8'hC3;
        shadow[16] = 8'hC3;
        step(1'b0);
        step(1'b0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_dq_o", 32'(dq_o), 32'd0);
        #2 rstn = 1'b1;
        step(1'b0);
        // both ports requesting together from reset: port 0 first, then strict alternation
        base = gnt_log.size();
        for (int i = 0; i < 4; i++) begin
            q[0].push_back(rand_acc());
            q[1].push_back(rand_acc());
        end
        settle(80);
        chk("order_len", 32'(gnt_log.size() - base), 32'd8);
        for (int i = 0; i < 8 && base + i < gnt_log.size(); i++) chk("order", 32'(gnt_log[base + i]), 32'(i % 2));
        q[1].push_back(mk(1'b1, 17'h1ABCD, 8'h5A));
        settle(20);
        chk("wr_1abcd", 32'(sram_rd(32'h1ABCD)), 32'h5A);
        q[0].push_back(mk(1'b0, 17'h00010, 8'h00));
        settle(20);
        chk("rd_c3", 32'(bus.rdata), 32'hC3);
        ack_log.delete();
        for (int i = 0; i < 3; i++) q[1].push_back(mk(1'b0, AW'(i), 8'h00));
        settle(30);
        chk("b2b_acks", 32'(ack_log.size()), 32'd3);
        for (int i = 1; i < ack_log.size(); i++) chk("b2b_gap", 32'(ack_log[i] - ack_log[i-1]), 32'(S + 3));
        for (int i = 0; i < 400; i++) step(1'b1);
        settle(100);
        // reset while the write strobe is low
        q[0].push_back(mk(1'b1, 17'h1FFFE, 8'h99));
        for (int i = 0; i < 20 && wen !== 1'b0; i++) step(1'b0);
        chk("wen_low_seen", 32'(wen), 32'd0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_wen", 32'(wen), 32'd1);
        chk("rst_async_cen", 32'(cen), 32'd1);
        chk("rst_async_oen", 32'(oen), 32'd1);
        chk("rst_async_dq_oe", 32'(dq_oe), 32'd0);
        chk("rst_async_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0;
            q[p].delete();
        end
        cv      = 1'b0;
        last    = 1;
        last_rd = '0;
        drive();
        step(1'b0);
        step(1'b0);
        #2 rstn = 1'b1;
        q[1].push_back(mk(1'b1, 17'h00005, 8'h3C));
        q[1].push_back(mk(1'b0, 17'h00005, 8'h00));
        settle(30);
        chk("post_rst_rd", 32'(bus.rdata), 32'h3C);
        // single-cycle strobe build
        s1_access(1'b1, 17'h00123, 8'hFF, ack_at, low_w, low_r);
        chk("s1_wr_ack_at", 32'(ack_at), 32'd2);
        chk("s1_wr_wen_w", 32'(low_w), 32'd1);
        chk("s1_wr_oen_w", 32'(low_r), 32'd0);
        s1_access(1'b0, 17'h00123, 8'h00, ack_at, low_w, low_r);
        chk("s1_rd_ack_at", 32'(ack_at), 32'd2);
        chk("s1_rd_oen_w", 32'(low_r), 32'd1);
        chk("s1_rd_wen_w", 32'(low_w), 32'd0);
        chk("s1_rd_data", 32'(bus1.rdata), 32'hFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
